// File: rtl/cluster_pkg.sv
// Shared helpers for the cluster primary finder: width math and counter limits.
package cluster_pkg;

    localparam logic [15:0] CNT_SAT_MAX = 16'hFFFF;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    function automatic int unsigned mxpads(input int unsigned rows, input int unsigned keys);
        return rows * keys;
    endfunction

endpackage

// File: rtl/cluster_run_counter.sv
// Per-pad saturating run length over one row: min(run starting at pad, N) - 1,
// assuming the pad itself is set. Pads past the row end read as zero.
module cluster_run_counter #(
    parameter int unsigned MXKEYS     = 192,
    parameter int unsigned MXCLSTSIZE = 8,
    parameter int unsigned CNTBITS    = 3
) (
    input  logic [MXKEYS-1:0]         row_bits,
    output logic [MXKEYS*CNTBITS-1:0] run_cnts
);

    logic [MXKEYS+MXCLSTSIZE-1:0] padded;
    logic [CNTBITS-1:0]           acc;
    logic                         live;

    assign padded = {{MXCLSTSIZE{1'b0}}, row_bits};

    always_comb begin
        run_cnts = '0;
        acc      = '0;
        live     = 1'b0;
        for (int unsigned k = 0; k < MXKEYS; k++) begin
            acc  = '0;
            live = 1'b1;
            for (int unsigned i = 1; i < MXCLSTSIZE; i++) begin
                live = live & padded[k+i];
                acc  = acc + CNTBITS'(live);
            end
            run_cnts[k*CNTBITS +: CNTBITS] = acc;
        end
    end

endmodule

// File: rtl/cluster_primary_finder.sv
// Flags cluster primaries and their size-1 per pad, 2-cycle pipeline.
// Optional per-row primary counters: define PRIMARY_ROW_COUNT_EN.
module cluster_primary_finder
    import cluster_pkg::*;
#(
    parameter int unsigned  MXROWS     = 8,
    parameter int unsigned  MXKEYS     = 192,
    parameter int unsigned  MXCLSTSIZE = 8,
    parameter int unsigned  MXSPLITS   = 1,
    localparam int unsigned MXPADS     = mxpads(MXROWS, MXKEYS),
    localparam int unsigned CNTBITS    = clog2(MXCLSTSIZE)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [MXPADS-1:0]         sbits,
    input  logic                      sbits_valid,
    input  logic [MXROWS-1:0]         row_mask,
    input  logic                      split_en,
    output logic [MXPADS-1:0]         vpfs,
    output logic [MXPADS*CNTBITS-1:0] cnts,
    output logic                      vpfs_valid
`ifdef PRIMARY_ROW_COUNT_EN
    ,
    input  logic                      cnt_clear,
    output logic [MXROWS*16-1:0]      row_prim_cnt
`endif
);

    // Zero padding below pad 0 lets split windows run off the row edge without guards.
    localparam int unsigned PAD = MXCLSTSIZE * MXSPLITS + 1;

    logic [MXPADS-1:0]         mask_pads;
    logic [MXPADS-1:0]         sbits_d, sbits_q;
    logic                      valid_d, valid_q;
    logic                      split_d, split_q;
    logic [MXPADS-1:0]         vpfs_d, vpfs_q;
    logic [MXPADS*CNTBITS-1:0] cnts_d, cnts_q;
    logic                      vpfs_valid_d, vpfs_valid_q;

    always_comb begin
        mask_pads = '0;
        for (int unsigned r = 0; r < MXROWS; r++) begin
            mask_pads[r*MXKEYS +: MXKEYS] = {MXKEYS{row_mask[r]}};
        end
        sbits_d      = sbits_valid ? (sbits & ~mask_pads) : '0;
        valid_d      = sbits_valid;
        split_d      = sbits_valid & split_en;
        vpfs_valid_d = valid_q;
    end

    for (genvar r = 0; r < MXROWS; r++) begin : g_row
        logic [MXKEYS-1:0]         row_bits;
        logic [MXKEYS-1:0]         row_vpfs;
        logic [MXKEYS*CNTBITS-1:0] row_runs;
        logic [MXKEYS*CNTBITS-1:0] row_cnts;
        logic [MXKEYS+PAD-1:0]     extp;
        logic                      split_hit;
        logic                      seg_ok;

        assign row_bits = sbits_q[r*MXKEYS +: MXKEYS];
        assign extp     = {row_bits, {PAD{1'b0}}};

        cluster_run_counter #(
            .MXKEYS     (MXKEYS),
            .MXCLSTSIZE (MXCLSTSIZE),
            .CNTBITS    (CNTBITS)
        ) u_runs (
            .row_bits (row_bits),
            .run_cnts (row_runs)
        );

        // Split primary: exactly j*N ones immediately before pad k, preceded by a zero.
        always_comb begin
            row_vpfs  = '0;
            row_cnts  = '0;
            split_hit = 1'b0;
            seg_ok    = 1'b0;
            for (int unsigned k = 0; k < MXKEYS; k++) begin
                split_hit = 1'b0;
                for (int unsigned j = 1; j <= MXSPLITS; j++) begin
                    seg_ok = ~extp[k+PAD-1-j*MXCLSTSIZE];
                    for (int unsigned i = 0; i < MXCLSTSIZE * MXSPLITS; i++) begin
                        if (i < j * MXCLSTSIZE) seg_ok = seg_ok & extp[k+PAD-1-i];
                    end
                    split_hit = split_hit | seg_ok;
                end
                row_vpfs[k] = row_bits[k] & (~extp[k+PAD-1] | (split_q & split_hit));
                row_cnts[k*CNTBITS +: CNTBITS] = row_vpfs[k] ? row_runs[k*CNTBITS +: CNTBITS] : '0;
            end
        end

        assign vpfs_d[r*MXKEYS +: MXKEYS]                 = row_vpfs;
        assign cnts_d[r*MXKEYS*CNTBITS +: MXKEYS*CNTBITS] = row_cnts;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sbits_q      <= '0;
            valid_q      <= 1'b0;
            split_q      <= 1'b0;
            vpfs_q       <= '0;
            cnts_q       <= '0;
            vpfs_valid_q <= 1'b0;
        end else begin
            sbits_q      <= sbits_d;
            valid_q      <= valid_d;
            split_q      <= split_d;
            vpfs_q       <= vpfs_d;
            cnts_q       <= cnts_d;
            vpfs_valid_q <= vpfs_valid_d;
        end
    end

    assign vpfs       = vpfs_q;
    assign cnts       = cnts_q;
    assign vpfs_valid = vpfs_valid_q;

`ifdef PRIMARY_ROW_COUNT_EN
    logic [MXROWS-1:0][15:0] row_cnt_d, row_cnt_q;
    logic [16:0]             sum;

    // Sum cannot exceed 17 bits, so bit 16 alone signals saturation.
    always_comb begin
        row_cnt_d = row_cnt_q;
        sum       = '0;
        for (int unsigned r = 0; r < MXROWS; r++) begin
            sum = {1'b0, row_cnt_q[r]};
            for (int unsigned k = 0; k < MXKEYS; k++) begin
                sum = sum + {16'b0, vpfs_q[r*MXKEYS+k]};
            end
            if (cnt_clear)         row_cnt_d[r] = '0;
            else if (vpfs_valid_q) row_cnt_d[r] = sum[16] ? CNT_SAT_MAX : sum[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) row_cnt_q <= '0;
        else       row_cnt_q <= row_cnt_d;
    end

    assign row_prim_cnt = row_cnt_q;
`endif

endmodule

// File: tb/tb_cluster_primary_finder.sv
// Scoreboard bench for cluster_primary_finder (N=8, MXSPLITS=1).
module tb_cluster_primary_finder;

    localparam int ROWS = 8;
    localparam int KEYS = 192;
    localparam int N    = 8;
    localparam int SPL  = 1;
    localparam int PADS = ROWS * KEYS;
    localparam int CB   = 3;

    typedef struct {
        logic [PADS-1:0]    v;
        logic [PADS*CB-1:0] c;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [PADS-1:0]     sbits = '0;
    logic                sbits_valid = 1'b0;
    logic [ROWS-1:0]     row_mask = '0;
    logic                split_en = 1'b0;
    logic [PADS-1:0]     vpfs;
    logic [PADS*CB-1:0]  cnts;
    logic                vpfs_valid;
`ifdef PRIMARY_ROW_COUNT_EN
    logic                cnt_clear = 1'b0;
    logic [ROWS*16-1:0]  row_prim_cnt;
`endif

    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];

    cluster_primary_finder #(
        .MXROWS     (ROWS),
        .MXKEYS     (KEYS),
        .MXCLSTSIZE (N),
        .MXSPLITS   (SPL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sbits       (sbits),
        .sbits_valid (sbits_valid),
        .row_mask    (row_mask),
        .split_en    (split_en),
        .vpfs        (vpfs),
        .cnts        (cnts),
        .vpfs_valid  (vpfs_valid)
`ifdef PRIMARY_ROW_COUNT_EN
        ,
        .cnt_clear    (cnt_clear),
        .row_prim_cnt (row_prim_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: walk each row tracking the run length ending at the previous pad.
    function automatic void model(input logic [PADS-1:0] s, input logic [ROWS-1:0] m, input logic sp,
                                  output logic [PADS-1:0] v, output logic [PADS*CB-1:0] c);
        int prev, len, p;
        v = '0;
        c = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!m[r]) begin
                prev = 0;
                for (int k = 0; k < KEYS; k++) begin
                    p = r * KEYS + k;
                    if (s[p]) begin
                        if (prev == 0 || (sp && (prev % N) == 0 && (prev / N) <= SPL)) begin
                            v[p] = 1'b1;
                            len  = 0;
                            while (k + len < KEYS && len < N && s[p+len]) len++;
                            c[p*CB +: CB] = CB'(len - 1);
                        end
                        prev++;
                    end else begin
                        prev = 0;
                    end
                end
            end
        end
    endfunction

    function automatic int first_diff(input logic [PADS-1:0] av, input logic [PADS-1:0] ev,
                                      input logic [PADS*CB-1:0] ac, input logic [PADS*CB-1:0] ec);
        for (int p = 0; p < PADS; p++) begin
            if (av[p] !== ev[p] || ac[p*CB +: CB] !== ec[p*CB +: CB]) return p;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [PADS-1:0] s, input logic [ROWS-1:0] m, input logic sp);
        exp_t e;
        model(s, m, sp, e.v, e.c);
        sb.push_back(e);
        sbits       = s;
        row_mask    = m;
        split_en    = sp;
        sbits_valid = 1'b1;
        step();
        sbits_valid = 1'b0;
        sbits       = '0;
    endtask

    task automatic get(output logic [PADS-1:0] ov, output logic [PADS*CB-1:0] oc,
                       output exp_t e, output int lat);
        ov  = '0;
        oc  = '0;
        e.v = '0;
        e.c = '0;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            if (vpfs_valid === 1'b1) begin
                lat = i;
                ov  = vpfs;
                oc  = cnts;
                if (sb.size() != 0) e = sb.pop_front();
                step();
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        sbits       = '1;
        sbits_valid = 1'b1;
        repeat (3) step();
        total++;
        if (vpfs_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", vpfs_valid);
        else passed++;
        total++;
        if (vpfs !== '0 || cnts !== '0) $display("FAIL reset_outputs: vpfs/cnts nonzero during reset");
        else passed++;
        sbits_valid = 1'b0;
        sbits       = '0;
        reset       = 1'b0;
        step();
        total++;
        if (vpfs_valid !== 1'b0) $display("FAIL reset_release: valid got %b, expected 0", vpfs_valid);
        else passed++;
    endtask

    task automatic test_isolated();
        logic [PADS-1:0] s, ov, ev;
        logic [PADS*CB-1:0] oc;
        exp_t e;
        int lat, d;
        s = '0; s[0] = 1'b1; s[5] = 1'b1; s[191] = 1'b1;
        send(s, '0, 1'b0);
        get(ov, oc, e, lat);
        total++;
        if (lat !== 1) $display("FAIL iso_latency: got %0d, expected 1", lat);
        else passed++;
        ev = '0; ev[0] = 1'b1; ev[5] = 1'b1; ev[191] = 1'b1;
        total++;
        if (ov !== ev) begin
            d = first_diff(ov, ev, '0, '0);
            $display("FAIL iso_vpfs: pad %0d got %b, expected %b", d, ov[d], ev[d]);
        end else passed++;
        total++;
        if (oc !== '0) $display("FAIL iso_cnts: got nonzero cnt, expected all 0");
        else passed++;
        total++;
        if (ov !== e.v || oc !== e.c) begin
            d = first_diff(ov, e.v, oc, e.c);
            $display("FAIL iso_sb: pad %0d vpf=%b cnt=%0d, expected vpf=%b cnt=%0d",
                     d, ov[d], oc[d*CB +: CB], e.v[d], e.c[d*CB +: CB]);
        end else passed++;
    endtask

    task automatic test_run();
        logic [PADS-1:0] s, ov, ev;
        logic [PADS*CB-1:0] oc;
        exp_t e;
        int lat;
        s = '0;
        for (int k = 10; k <= 14; k++) s[3*KEYS+k] = 1'b1;
        send(s, '0, 1'b1);
        get(ov, oc, e, lat);
        ev = '0; ev[3*KEYS+10] = 1'b1;
        total++;
        if (ov !== ev) $display("FAIL run_vpfs: pad 586 got %b, pads 587..590 got %b, expected 1 and 0000",
                                ov[586], ov[590:587]);
        else passed++;
        total++;
        if (oc[586*CB +: CB] !== 3'd4 || oc[587*CB +: 4*CB] !== '0)
            $display("FAIL run_cnt: pad 586 got %0d, expected 4", oc[586*CB +: CB]);
        else passed++;
        total++;
        if (ov !== e.v || oc !== e.c) $display("FAIL run_sb: frame differs from scoreboard");
        else passed++;
    endtask

    task automatic test_split();
        logic [PADS-1:0] s, ov, ev;
        logic [PADS*CB-1:0] oc;
        exp_t e;
        int lat;
        s = '0;
        for (int k = 0; k < 20; k++) s[k] = 1'b1;
        send(s, '0, 1'b1);
        send(s, '0, 1'b0);
        get(ov, oc, e, lat);
        ev = '0; ev[0] = 1'b1; ev[8] = 1'b1;
        total++;
        if (ov !== ev || oc[0 +: CB] !== 3'd7 || oc[8*CB +: CB] !== 3'd7)
            $display("FAIL split_on: pads 0/8/16 vpf=%b%b%b cnt0=%0d cnt8=%0d, expected 110 7 7",
                     ov[0], ov[8], ov[16], oc[0 +: CB], oc[8*CB +: CB]);
        else passed++;
        total++;
        if (ov !== e.v || oc !== e.c) $display("FAIL split_on_sb: frame differs from scoreboard");
        else passed++;
        get(ov, oc, e, lat);
        ev = '0; ev[0] = 1'b1;
        total++;
        if (ov !== ev || oc[0 +: CB] !== 3'd7 || oc[8*CB +: CB] !== '0)
            $display("FAIL split_off: pads 0/8 vpf=%b%b cnt0=%0d, expected 10 7", ov[0], ov[8], oc[0 +: CB]);
        else passed++;
        total++;
        if (ov !== e.v || oc !== e.c) $display("FAIL split_off_sb: frame differs from scoreboard");
        else passed++;
    endtask

    task automatic test_row_edge();
        logic [PADS-1:0] s, ov, ev;
        logic [PADS*CB-1:0] oc;
        exp_t e;
        int lat;
        s = '0;
        for (int k = 188; k < 192; k++) s[KEYS+k] = 1'b1;
        s[2*KEYS] = 1'b1;
        send(s, '0, 1'b1);
        get(ov, oc, e, lat);
        ev = '0; ev[380] = 1'b1; ev[384] = 1'b1;
        total++;
        if (ov !== ev) $display("FAIL edge_vpfs: pad 380 got %b, pad 384 got %b, expected 1 1", ov[380], ov[384]);
        else passed++;
        total++;
        if (oc[380*CB +: CB] !== 3'd3 || oc[384*CB +: CB] !== 3'd0)
            $display("FAIL edge_cnts: got %0d and %0d, expected 3 and 0", oc[380*CB +: CB], oc[384*CB +: CB]);
        else passed++;
    endtask

    task automatic test_mask();
        logic [PADS-1:0] s, ov, ev;
        logic [PADS*CB-1:0] oc;
        exp_t e;
        int lat, d;
        s = '0;
        s[575:384] = '1;
        s[3] = 1'b1; s[4] = 1'b1; s[PADS-1] = 1'b1;
        send(s, 8'h04, 1'b1);
        get(ov, oc, e, lat);
        ev = '0; ev[3] = 1'b1; ev[PADS-1] = 1'b1;
        total++;
        if (ov !== ev) begin
            d = first_diff(ov, ev, '0, '0);
            $display("FAIL mask_vpfs: pad %0d got %b, expected %b", d, ov[d], ev[d]);
        end else passed++;
        total++;
        if (oc[384*CB +: KEYS*CB] !== '0 || oc[3*CB +: CB] !== 3'd1)
            $display("FAIL mask_cnts: row2 cnts nonzero or pad 3 cnt %0d, expected 1", oc[3*CB +: CB]);
        else passed++;
        total++;
        if (ov !== e.v || oc !== e.c) $display("FAIL mask_sb: frame differs from scoreboard");
        else passed++;
    endtask

    task automatic test_back_to_back();
        sb.delete();
        fork
            begin
                logic [PADS-1:0] s;
                logic [ROWS-1:0] m;
                for (int f = 0; f < 6; f++) begin
                    for (int p = 0; p < PADS; p++) s[p] = ($urandom_range(0, 99) < 55);
                    if (f == 0) s[KEYS-1:0] = '1;
                    m = (f < 3) ? '0 : ROWS'($urandom_range(0, 255));
                    send(s, m, f[0] | (f == 0));
                end
            end
            begin
                logic [PADS-1:0] ov;
                logic [PADS*CB-1:0] oc;
                exp_t e;
                int lat, d;
                for (int f = 0; f < 6; f++) begin
                    get(ov, oc, e, lat);
                    total++;
                    if (lat < 0) $display("FAIL b2b_timeout: frame %0d never became valid", f);
                    else if (ov !== e.v || oc !== e.c) begin
                        d = first_diff(ov, e.v, oc, e.c);
                        $display("FAIL b2b_frame%0d: pad %0d vpf=%b cnt=%0d, expected vpf=%b cnt=%0d",
                                 f, d, ov[d], oc[d*CB +: CB], e.v[d], e.c[d*CB +: CB]);
                    end else passed++;
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        logic [PADS-1:0] s;
        s = '0; s[7] = 1'b1;
        send(s, '0, 1'b0);
        reset = 1'b1;
        step();
        total++;
        if (vpfs_valid !== 1'b0 || vpfs !== '0 || cnts !== '0)
            $display("FAIL midreset_out: valid got %b, expected 0 with zero outputs", vpfs_valid);
        else passed++;
        reset = 1'b0;
        step();
        total++;
        if (vpfs_valid !== 1'b0 || vpfs !== '0)
            $display("FAIL midreset_flush: valid got %b, expected 0 (frame discarded)", vpfs_valid);
        else passed++;
        sb.delete();
    endtask

`ifdef PRIMARY_ROW_COUNT_EN
    task automatic test_row_count();
        logic [PADS-1:0] s2, alt;
        s2 = '0; s2[0] = 1'b1; s2[5] = 1'b1;
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        repeat (3) send(s2, '0, 1'b0);
        repeat (3) step();
        total++;
        if (row_prim_cnt[15:0] !== 16'd6 || row_prim_cnt[31:16] !== 16'd0)
            $display("FAIL rowcnt_six: got %0d, expected 6", row_prim_cnt[15:0]);
        else passed++;
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        alt = '0;
        for (int k = 0; k < KEYS; k += 2) alt[k] = 1'b1;
        sbits = alt; row_mask = '0; sbits_valid = 1'b1;
        repeat (682) step();
        sbits = '0;
        for (int k = 0; k < 124; k += 2) sbits[k] = 1'b1;
        step();
        sbits_valid = 1'b0; sbits = '0;
        repeat (3) step();
        total++;
        if (row_prim_cnt[15:0] !== 16'hFFFE) $display("FAIL rowcnt_preload: got %h, expected fffe", row_prim_cnt[15:0]);
        else passed++;
        send(s2, '0, 1'b0);
        repeat (3) step();
        total++;
        if (row_prim_cnt[15:0] !== 16'hFFFF) $display("FAIL rowcnt_sat: got %h, expected ffff", row_prim_cnt[15:0]);
        else passed++;
        send(s2, '0, 1'b0);
        repeat (3) step();
        total++;
        if (row_prim_cnt[15:0] !== 16'hFFFF) $display("FAIL rowcnt_hold: got %h, expected ffff", row_prim_cnt[15:0]);
        else passed++;
        send(s2, '0, 1'b0);
        step();
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        step();
        total++;
        if (row_prim_cnt[15:0] !== 16'h0000) $display("FAIL rowcnt_clear: got %h, expected 0", row_prim_cnt[15:0]);
        else passed++;
        sb.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_isolated();
        test_run();
        test_split();
        test_row_edge();
        test_mask();
        test_back_to_back();
        test_reset_mid();
`ifdef PRIMARY_ROW_COUNT_EN
        test_row_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
